// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller:
// FSM state encodings and register-file constants.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // $zero is hard-wired, so a load into it never creates a dependency.
    localparam int REG_ZERO = 0;

    function automatic logic is_advancing(input state_t st);
        return (st == ST_RUN) || (st == ST_STEP);
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Request, hazard and enable signals between the pipeline datapath/debug unit
// and the sequencing controller.
interface pipeline_ctrl_if #(
    parameter int REG_SIZE = 5,
    parameter int CNT_SIZE = 32
);
    logic                i_run_req;
    logic                i_step_req;
    logic                i_halt_wb;
    logic                i_idex_mem_read;
    logic [REG_SIZE-1:0] i_idex_rt;
    logic [REG_SIZE-1:0] i_ifid_rs;
    logic [REG_SIZE-1:0] i_ifid_rt;
    logic                i_flush_req;

    logic                o_pipeline_enable;
    logic                o_pc_enable;
    logic                o_ifid_enable;
    logic                o_ifid_flush;
    logic                o_idex_bubble;
    logic [1:0]          o_state;
    logic                o_done;
    logic [CNT_SIZE-1:0] o_cycle_count;
    logic [CNT_SIZE-1:0] o_stall_count;

    // Datapath / debug side.
    modport master (
        output i_run_req, i_step_req, i_halt_wb, i_idex_mem_read,
               i_idex_rt, i_ifid_rs, i_ifid_rt, i_flush_req,
        input  o_pipeline_enable, o_pc_enable, o_ifid_enable, o_ifid_flush,
               o_idex_bubble, o_state, o_done, o_cycle_count, o_stall_count
    );

    // Controller side.
    modport slave (
        input  i_run_req, i_step_req, i_halt_wb, i_idex_mem_read,
               i_idex_rt, i_ifid_rs, i_ifid_rt, i_flush_req,
        output o_pipeline_enable, o_pc_enable, o_ifid_enable, o_ifid_flush,
               o_idex_bubble, o_state, o_done, o_cycle_count, o_stall_count
    );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard comparator: the load in ID_EX writes a register that the
// instruction in IF_ID reads.
module hazard_detect
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_SIZE = 5
) (
    input  logic                mem_read,
    input  logic [REG_SIZE-1:0] idex_rt,
    input  logic [REG_SIZE-1:0] ifid_rs,
    input  logic [REG_SIZE-1:0] ifid_rt,
    output logic                load_use
);

    assign load_use = mem_read
                   && (idex_rt != REG_SIZE'(REG_ZERO))
                   && ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing controller: run / single-step / halt FSM, load-use
// stall and branch flush enables, and saturating cycle/stall counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_SIZE = 5,
    parameter int CNT_SIZE = 32
) (
    input  logic          i_clock,
    input  logic          i_reset,
    pipeline_ctrl_if.slave bus
);

    localparam logic [CNT_SIZE-1:0] CNT_MAX = '1;

    state_t              state;
    state_t              state_nx;
    logic                adv;
    logic                lu;
    logic [CNT_SIZE-1:0] cycle_cnt;
    logic [CNT_SIZE-1:0] stall_cnt;

    hazard_detect #(.REG_SIZE(REG_SIZE)) u_hazard (
        .mem_read (bus.i_idex_mem_read),
        .idex_rt  (bus.i_idex_rt),
        .ifid_rs  (bus.i_ifid_rs),
        .ifid_rt  (bus.i_ifid_rt),
        .load_use (lu)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves
        // state_nx unassigned and infers a latch.
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (bus.i_run_req) begin
                    state_nx = ST_RUN;
                end else if (bus.i_step_req) begin
                    state_nx = ST_STEP;
                end
            end
            ST_RUN: begin
                if (bus.i_halt_wb) begin
                    state_nx = ST_DONE;
                end
            end
            ST_STEP: begin
                state_nx = bus.i_halt_wb ? ST_DONE : ST_IDLE;
            end
            ST_DONE: begin
                state_nx = ST_DONE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // A flush discards the stalled instruction, so it overrides the stall.
    always_comb begin
        adv                   = is_advancing(state);
        bus.o_pipeline_enable = adv;
        bus.o_ifid_flush      = adv && bus.i_flush_req;
        bus.o_idex_bubble     = adv && (bus.i_flush_req || lu);
        bus.o_pc_enable       = adv && (bus.i_flush_req || !lu);
        bus.o_ifid_enable     = adv && (bus.i_flush_req || !lu);
        bus.o_state           = state;
        bus.o_done            = (state == ST_DONE);
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            cycle_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (adv && (cycle_cnt != CNT_MAX)) begin
                cycle_cnt <= cycle_cnt + 1'b1;
            end
            if (adv && lu && !bus.i_flush_req && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    assign bus.o_cycle_count = cycle_cnt;
    assign bus.o_stall_count = stall_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: scoreboarded output records, a
// hazard vector table applied in RUN, and hand-written FSM sequences.
module tb_pipeline_ctrl;
    import pipeline_ctrl_pkg::*;

    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        state_t st;
        logic   pe, pc, ife, fl, bub, dn;
        int     cyc, stl;
    } exp_t;

    typedef struct packed {
        logic       mr;
        logic [4:0] irt, rs, rt;
        logic       fl;
        logic       e_pc, e_bub, e_fl, e_stall;
    } vec_t;

    exp_t  sb[$];
    string tag_q[$];
    vec_t  vecs[9];

    pipeline_ctrl_if #(.REG_SIZE(5), .CNT_SIZE(32)) bus ();
    pipeline_ctrl_if #(.REG_SIZE(5), .CNT_SIZE(4))  bus4 ();

    pipeline_ctrl #(.REG_SIZE(5), .CNT_SIZE(32)) dut (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (bus.slave)
    );

    pipeline_ctrl #(.REG_SIZE(5), .CNT_SIZE(4)) dut4 (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (bus4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: actual=still running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input state_t st, input logic pe, input logic pc,
                                input logic fl, input logic bub, input int cyc, input int stl);
        exp_t e;
        e.st  = st;
        e.pe  = pe;
        e.pc  = pc;
        e.ife = pc;
        e.fl  = fl;
        e.bub = bub;
        e.dn  = (st == ST_DONE);
        e.cyc = cyc;
        e.stl = stl;
        return e;
    endfunction

    task automatic compare_front();
        exp_t  e;
        string t;
        e = sb.pop_front();
        t = tag_q.pop_front();
        check({t, ".state"},    32'(bus.o_state),           32'(e.st));
        check({t, ".pipe_en"},  32'(bus.o_pipeline_enable), 32'(e.pe));
        check({t, ".pc_en"},    32'(bus.o_pc_enable),       32'(e.pc));
        check({t, ".ifid_en"},  32'(bus.o_ifid_enable),     32'(e.ife));
        check({t, ".flush"},    32'(bus.o_ifid_flush),      32'(e.fl));
        check({t, ".bubble"},   32'(bus.o_idex_bubble),     32'(e.bub));
        check({t, ".done"},     32'(bus.o_done),            32'(e.dn));
        check({t, ".cycles"},   bus.o_cycle_count,          32'(e.cyc));
        check({t, ".stalls"},   bus.o_stall_count,          32'(e.stl));
    endtask

    // Expectation is queued when the stimulus is applied and compared once
    // the outputs have settled, well away from either clock edge.
    task automatic verify(input string tag, input exp_t e, input int dly);
        sb.push_back(e);
        tag_q.push_back(tag);
        if (dly > 0) #(dly);
        compare_front();
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.i_run_req = 1'b0;       bus.i_step_req = 1'b0;
        bus.i_halt_wb = 1'b0;       bus.i_idex_mem_read = 1'b0;
        bus.i_idex_rt = '0;         bus.i_ifid_rs = '0;
        bus.i_ifid_rt = '0;         bus.i_flush_req = 1'b0;
        bus4.i_run_req = 1'b0;      bus4.i_step_req = 1'b0;
        bus4.i_halt_wb = 1'b0;      bus4.i_idex_mem_read = 1'b0;
        bus4.i_idex_rt = '0;        bus4.i_ifid_rs = '0;
        bus4.i_ifid_rt = '0;        bus4.i_flush_req = 1'b0;
    endtask

    // Asynchronous reset applied mid-cycle; outputs must clear before any edge.
    task automatic apply_reset(input string tag);
        rst_n = 1'b0;
        #1;
        verify(tag, mk(ST_IDLE, 0, 0, 0, 0, 0, 0), 0);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        int exp_cyc;
        int exp_stl;

        //            mr irt rs  rt  fl   pc bub fl stall
        vecs[0] = '{1'b1, 5'd5,  5'd5,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 5'd0,  5'd5,  5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 5'd0,  5'd0,  5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 5'd7,  5'd3,  5'd7,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 5'd5,  5'd5,  5'd5,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 5'd5,  5'd5,  5'd0,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 5'd31, 5'd31, 5'd31, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[8] = '{1'b1, 5'd30, 5'd31, 5'd29, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        // Power-on reset.
        rst_n = 1'b0;
        clear_in();
        #2;
        verify("por", mk(ST_IDLE, 0, 0, 0, 0, 0, 0), 0);
        #8;
        rst_n = 1'b1;

        // Three single steps with idle gaps; a step request held during STEP
        // on the last one must be ignored.
        for (int i = 0; i < 3; i++) begin
            step_clk();
            bus.i_step_req = 1'b1;
            verify($sformatf("step%0d_req", i), mk(ST_IDLE, 0, 0, 0, 0, i, 0), 2);
            step_clk();
            bus.i_step_req = (i == 2);
            verify($sformatf("step%0d_adv", i), mk(ST_STEP, 1, 1, 0, 0, i, 0), 2);
            step_clk();
            bus.i_step_req = 1'b0;
            verify($sformatf("step%0d_back", i), mk(ST_IDLE, 0, 0, 0, 0, i + 1, 0), 2);
        end

        // Run up to seven cycles, then reset mid-RUN.
        step_clk();
        bus.i_run_req = 1'b1;
        verify("run_req", mk(ST_IDLE, 0, 0, 0, 0, 3, 0), 2);
        step_clk();
        bus.i_run_req = 1'b0;
        verify("run_enter", mk(ST_RUN, 1, 1, 0, 0, 3, 0), 2);
        for (int k = 1; k <= 4; k++) begin
            step_clk();
            verify($sformatf("run_c%0d", 3 + k), mk(ST_RUN, 1, 1, 0, 0, 3 + k, 0), 2);
        end
        apply_reset("rst_mid_run");
        step_clk();
        verify("post_rst", mk(ST_IDLE, 0, 0, 0, 0, 0, 0), 2);

        // Hazard / flush vector table applied one cycle each in RUN.
        bus.i_run_req = 1'b1;
        step_clk();
        bus.i_run_req = 1'b0;
        verify("hz_enter", mk(ST_RUN, 1, 1, 0, 0, 0, 0), 2);
        exp_cyc = 0;
        exp_stl = 0;
        for (int i = 0; i < 9; i++) begin
            step_clk();
            exp_cyc++;
            if (i > 0 && vecs[i-1].e_stall) exp_stl++;
            bus.i_idex_mem_read = vecs[i].mr;
            bus.i_idex_rt       = vecs[i].irt;
            bus.i_ifid_rs       = vecs[i].rs;
            bus.i_ifid_rt       = vecs[i].rt;
            bus.i_flush_req     = vecs[i].fl;
            verify($sformatf("hz_v%0d", i),
                   mk(ST_RUN, 1, vecs[i].e_pc, vecs[i].e_fl, vecs[i].e_bub, exp_cyc, exp_stl), 2);
        end
        step_clk();
        exp_cyc++;
        if (vecs[8].e_stall) exp_stl++;
        clear_in();
        verify("hz_after", mk(ST_RUN, 1, 1, 0, 0, exp_cyc, exp_stl), 2);

        // Ten RUN cycles, halt, then DONE must absorb every request.
        apply_reset("rst_pre_halt");
        step_clk();
        bus.i_run_req = 1'b1;
        verify("halt_req", mk(ST_IDLE, 0, 0, 0, 0, 0, 0), 2);
        step_clk();
        bus.i_run_req = 1'b0;
        verify("halt_enter", mk(ST_RUN, 1, 1, 0, 0, 0, 0), 2);
        for (int k = 1; k <= 9; k++) begin
            step_clk();
            if (k == 9) bus.i_halt_wb = 1'b1;
            verify($sformatf("halt_c%0d", k), mk(ST_RUN, 1, 1, 0, 0, k, 0), 2);
        end
        step_clk();
        bus.i_halt_wb = 1'b0;
        verify("done_enter", mk(ST_DONE, 0, 0, 0, 0, 10, 0), 2);
        for (int k = 0; k < 3; k++) begin
            step_clk();
            bus.i_run_req   = 1'b1;
            bus.i_step_req  = 1'b1;
            bus.i_flush_req = 1'b1;
            verify($sformatf("done_hold%0d", k), mk(ST_DONE, 0, 0, 0, 0, 10, 0), 2);
        end
        step_clk();
        clear_in();
        verify("done_final", mk(ST_DONE, 0, 0, 0, 0, 10, 0), 2);

        // Narrow-counter instance: RUN beats STEP, cycle counter saturates.
        bus4.i_run_req  = 1'b1;
        bus4.i_step_req = 1'b1;
        #2;
        check("sat_pre_state", 32'(bus4.o_state), 32'(ST_IDLE));
        step_clk();
        bus4.i_run_req  = 1'b0;
        bus4.i_step_req = 1'b0;
        #2;
        check("sat_both_req_state", 32'(bus4.o_state), 32'(ST_RUN));
        check("sat_pipe_en", 32'(bus4.o_pipeline_enable), 32'd1);
        for (int k = 1; k <= 20; k++) begin
            step_clk();
            #2;
            if (k == 14) check("sat_c14", 32'(bus4.o_cycle_count), 32'd14);
            if (k == 15) check("sat_c15", 32'(bus4.o_cycle_count), 32'd15);
        end
        check("sat_c20", 32'(bus4.o_cycle_count), 32'd15);
        check("sat_state", 32'(bus4.o_state), 32'(ST_RUN));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Sequencing controller for the five-stage MIPS pipeline registers (IF_ID, ID_EX, EX_MEM, MEM_WB) and the PC. It decides when the pipeline advances: continuous run, single-step (debug unit) or frozen after a halt. It also inserts load-use stalls and branch/jump flushes. All pipeline registers update on negedge `i_clock`; this block updates its state on posedge, so every enable is stable half a cycle before it is sampled.

## Interface
Parameters:
- `REG_SIZE`, 5, register-address width
- `CNT_SIZE`, 32, cycle/stall counter width

Ports:
- `i_clock`  in  1  clock
- `i_reset`  in  1  asynchronous, active-low reset
- `i_run_req`  in  1  pulse: start continuous execution
- `i_step_req`  in  1  pulse: advance exactly one cycle
- `i_halt_wb`  in  1  halt instruction has reached MEM_WB output
- `i_idex_mem_read`  in  1  ID_EX holds a load
- `i_idex_rt`  in  REG_SIZE  ID_EX destination rt
- `i_ifid_rs`, `i_ifid_rt`  in  REG_SIZE each  source regs of the instruction in IF_ID
- `i_flush_req`  in  1  taken branch / jump / jr-jalr resolved this cycle
- `o_pipeline_enable`  out  1  enable for ID_EX, EX_MEM, MEM_WB
- `o_pc_enable`  out  1  PC write enable
- `o_ifid_enable`  out  1  IF_ID enable
- `o_ifid_flush`  out  1  load NOP into IF_ID
- `o_idex_bubble`  out  1  force ID_EX control fields to zero
- `o_state`  out  2  current FSM state
- `o_done`  out  1  program halted
- `o_cycle_count`  out  CNT_SIZE  cycles advanced
- `o_stall_count`  out  CNT_SIZE  load-use stall cycles

## Operation
- States: IDLE=0, RUN=1, STEP=2, DONE=3.
- `adv` = (state==RUN) || (state==STEP).
- IDLE transitions:
  - To RUN on `i_run_req`.
  - Else to STEP on `i_step_req`.
  - If both are asserted, RUN wins.
- STEP transitions:
  - Lasts exactly one clock.
  - Goes to DONE if `i_halt_wb`, else back to IDLE.
  - Step requests arriving during STEP are ignored.
- RUN: goes to DONE on `i_halt_wb`; `i_run_req` and `i_step_req` are ignored.
- DONE: absorbing; only reset leaves it. `o_done` = 1.
- Load-use hazard: `lu = i_idex_mem_read && i_idex_rt!=0 && (i_idex_rt==i_ifid_rs || i_idex_rt==i_ifid_rt)`.
- Output equations (combinational from the state register and current inputs):
  - `o_pipeline_enable = adv`
  - `o_ifid_flush = adv && i_flush_req`
  - `o_idex_bubble = adv && (i_flush_req || lu)`
  - `o_pc_enable = o_ifid_enable = adv && (i_flush_req || !lu)`
- Flush has priority over stall: the stalled instruction is on the wrong path and is discarded, so the PC advances to the target.
- Counters:
  - `o_cycle_count` increments every posedge with `adv`=1.
  - `o_stall_count` increments every posedge with `adv && lu && !i_flush_req`.
  - Both saturate at all-ones and never wrap.

## Timing
- Reset (async, `i_reset`=0): state=IDLE, counters=0, all enables 0, `o_done`=0. This applies immediately, including mid-RUN or in DONE.
- Deassertion is synchronous to posedge via the normal flop path; no request is honoured in the reset-release cycle unless it is sampled at a posedge after release.
- Request to advance:
  - `i_run_req` sampled at posedge N puts the state in RUN from N.
  - The first pipeline update is at negedge N+½.
- Step: `i_step_req` at posedge N yields exactly one negedge update (N+½); `o_pipeline_enable` is 0 again after posedge N+1.
- Halt: `i_halt_wb` sampled at posedge M in RUN sets the state to DONE at M. No pipeline update occurs at negedge M+½, and the counters stop at M.
- Hazard and flush outputs follow their inputs within the same cycle, with no added latency.
- Inputs are assumed synchronous to `i_clock`.

## Structure
- `pipeline_ctrl_pkg`: state encodings (`ST_IDLE`, `ST_RUN`, `ST_STEP`, `ST_DONE`) and the `REG_ZERO` constant.
- Sub-module `hazard_detect`: purely combinational `lu` comparator, with REG_SIZE as a parameter. The FSM, output logic and counters stay in the top module.

## Test plan
- Reset mid-RUN at `o_cycle_count`=7 → `o_state`=0, counts 0, all enables 0 immediately, before the next clock edge.
- IDLE, `i_step_req` pulse ×3 (idle gaps between) → exactly 3 cycles with `o_pipeline_enable`=1; `o_cycle_count`=3; `o_state` returns to 0 each time.
- RUN with `i_idex_mem_read`=1, `i_idex_rt`=5, `i_ifid_rs`=5 for one cycle → `o_pc_enable`=0, `o_ifid_enable`=0, `o_idex_bubble`=1, `o_pipeline_enable`=1, `o_stall_count`=1. Same stimulus with `i_idex_rt`=0 → no stall.
- Load-use and `i_flush_req` asserted together → `o_ifid_flush`=1, `o_idex_bubble`=1, `o_pc_enable`=1, `o_stall_count` unchanged.
- RUN 10 cycles, then `i_halt_wb`=1 → `o_state`=3, `o_done`=1, `o_cycle_count`=10 and frozen; subsequent `i_run_req`/`i_step_req` have no effect.
- `i_run_req` and `i_step_req` asserted together in IDLE → RUN. With CNT_SIZE=4, run 20 cycles → `o_cycle_count`=15 (saturated).
